// File: rtl/csa_accumulate_ctrl.sv
// ---------------------------------------------------------------------------
// csa_accumulate_ctrl
//
// Multi-operand accumulator controller for window/tap sums. Operands arrive
// over a valid/ready handshake and are folded 3:2 into redundant sum/carry
// registers, one per cycle, with no carry propagation on the accumulate path.
// The group's last operand triggers a single carry-propagate resolve, and the
// result is then held on a valid/ready output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand present
//   in_ready   operand can be accepted this cycle (depends on state only)
//   in_data    signed operand, XLEN bits
//   in_last    marks the final operand of a group
//   out_valid  result present
//   out_ready  consumer takes the result
//   out_data   resolved group sum, modulo 2^ACC_W
//   out_count  operand count of the group, saturating at 2^CNT_W-1
//
// carry_save_adder is the purely combinational 3:2 compressor used by the
// controller; it lives in this file so that the block is self-contained.
// ---------------------------------------------------------------------------

module carry_save_adder #(
    parameter int XLEN = 16
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] c,
    output logic [XLEN-1:0] sum,
    output logic [XLEN-1:0] c_out
);
    assign sum   = a ^ b ^ c;
    assign c_out = (a & b) | (a & c) | (b & c);
endmodule

module csa_accumulate_ctrl #(
    parameter int XLEN  = 8,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [XLEN-1:0]  in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [CNT_W-1:0]        out_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;

    logic [ACC_W-1:0]   c_shift;
    logic [ACC_W-1:0]   operand_ext;
    logic [ACC_W-1:0]   csa_sum;
    logic [ACC_W-1:0]   csa_c_out;
    logic               accept;
    logic               carry_msb_unused;

    function automatic logic signed [ACC_W-1:0] sign_extend(input logic signed [XLEN-1:0] x);
        logic signed [ACC_W-1:0] r;
        r = x;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        if (&x) begin
            return x;
        end
        return x + CNT_W'(1);
    endfunction

    // The carry vector carries weight 2; its MSB falls off the top, which is
    // exactly the modulo-2^ACC_W behaviour wanted for the result.
    assign c_shift          = {c_q[ACC_W-2:0], 1'b0};
    assign carry_msb_unused = c_q[ACC_W-1];
    assign operand_ext      = sign_extend(in_data);

    carry_save_adder #(
        .XLEN (ACC_W)
    ) u_csa (
        .a     (s_q),
        .b     (c_shift),
        .c     (operand_ext),
        .sum   (csa_sum),
        .c_out (csa_c_out)
    );

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUTPUT);
    assign accept    = in_valid & in_ready;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        case (state_q)
            IDLE: begin
                state_d = ACCUM;
            end
            ACCUM: begin
                if (accept) begin
                    s_d     = csa_sum;
                    c_d     = csa_c_out;
                    count_d = sat_inc(count_q);
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_data_d  = s_q + c_shift;
                out_count_d = count_q;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

endmodule

// File: tb/tb_csa_accumulate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulate_ctrl
//
// Directed bench for csa_accumulate_ctrl (XLEN=8, ACC_W=16, CNT_W=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------

module tb_csa_accumulate_ctrl;

    localparam int XLEN  = 8;
    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    logic                   clk       = 1'b0;
    logic                   rst_n     = 1'b0;
    logic                   in_valid  = 1'b0;
    logic                   in_last   = 1'b0;
    logic                   out_ready = 1'b1;
    logic signed [XLEN-1:0] in_data   = '0;
    logic                   in_ready;
    logic                   out_valid;
    logic [ACC_W-1:0]       out_data;
    logic [CNT_W-1:0]       out_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csa_accumulate_ctrl #(
        .XLEN  (XLEN),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until the edge that accepts it.
    task automatic send(input logic [XLEN-1:0] d, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check_eq("send_timeout", 32'(in_ready), 32'd1);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the edge that accepted the last operand.
    task automatic expect_result(input string tag, input logic [ACC_W-1:0] d,
                                 input logic [CNT_W-1:0] n);
        check_eq({tag, "_resolve_vld"}, 32'(out_valid), 32'd0);
        tick();
        check_eq({tag, "_vld"},   32'(out_valid), 32'd1);
        check_eq({tag, "_data"},  32'(out_data),  32'(d));
        check_eq({tag, "_count"}, 32'(out_count), 32'(n));
        check_eq({tag, "_rdy"},   32'(in_ready),  32'd0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        check_eq({tag, "_back_rdy"}, 32'(in_ready),  32'd1);
        check_eq({tag, "_back_vld"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and the dead cycle after release
        repeat (2) tick();
        check_eq("rst_rdy",   32'(in_ready),  32'd0);
        check_eq("rst_vld",   32'(out_valid), 32'd0);
        check_eq("rst_data",  32'(out_data),  32'd0);
        check_eq("rst_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("idle_rdy", 32'(in_ready), 32'd0);
        tick();
        check_eq("accum_rdy", 32'(in_ready), 32'd1);

        // Basic sum 1+2+3+4
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        send(8'd4, 1'b1);
        expect_result("basic", 16'h000A, 8'd4);
        drain("basic");

        // Signed: -128 + -1
        send(8'h80, 1'b0);
        send(8'hFF, 1'b1);
        expect_result("signed", 16'hFF7F, 8'd2);
        drain("signed");

        // Single term
        send(8'h7F, 1'b1);
        expect_result("single", 16'h007F, 8'd1);
        drain("single");

        // Backpressure with a pushy producer
        send(8'd10, 1'b0);
        out_ready = 1'b0;
        send(8'd20, 1'b1);
        expect_result("bp", 16'd30, 8'd2);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold_vld",   32'(out_valid), 32'd1);
            check_eq("bp_hold_data",  32'(out_data),  32'd30);
            check_eq("bp_hold_count", 32'(out_count), 32'd2);
            check_eq("bp_hold_rdy",   32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain("bp");
        send(8'd3, 1'b0);
        send(8'd4, 1'b1);
        expect_result("bp_next", 16'd7, 8'd2);
        drain("bp_next");

        // Wrap and count saturation: 600 * 127 = 76200 -> 0x29A8
        for (int i = 0; i < 600; i++) begin
            send(8'h7F, (i == 599));
        end
        expect_result("wrap", 16'h29A8, 8'd255);
        drain("wrap");

        // Reset in the middle of a group
        send(8'd9, 1'b0);
        send(8'd9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rdy",   32'(in_ready),  32'd0);
        check_eq("mid_rst_vld",   32'(out_valid), 32'd0);
        check_eq("mid_rst_data",  32'(out_data),  32'd0);
        check_eq("mid_rst_count", 32'(out_count), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("mid_idle_rdy", 32'(in_ready), 32'd0);
        tick();
        check_eq("mid_accum_rdy", 32'(in_ready), 32'd1);
        send(8'd5, 1'b0);
        send(8'd6, 1'b1);
        expect_result("after_rst", 16'h000B, 8'd2);
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
